// File: rtl/leg_queue_pkg.sv
// leg_queue_pkg: shared defaults and sizing helpers for the LEG FIFO queue.
package leg_queue_pkg;
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_DEPTH_LOG2 = 8;
    localparam int DEPTH              = 1 << DEFAULT_DEPTH_LOG2;

    // Occupancy needs one extra bit so that a completely full queue is representable.
    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction
endpackage

// File: rtl/leg_queue_if.sv
// leg_queue_if: PUSH/POP/VALUE request side and OUTPUT/status side of the queue.
interface leg_queue_if
    import leg_queue_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);
    logic                                PUSH;
    logic                                POP;
    logic [WIDTH-1:0]                    VALUE;
    logic [WIDTH-1:0]                    OUTPUT;
    logic                                EMPTY;
    logic                                FULL;
    logic [count_width(DEPTH_LOG2)-1:0]  COUNT;
    logic                                ERR;

    modport master (output PUSH, POP, VALUE, input OUTPUT, EMPTY, FULL, COUNT, ERR);
    modport slave  (input PUSH, POP, VALUE, output OUTPUT, EMPTY, FULL, COUNT, ERR);
endinterface

// File: rtl/leg_queue_ram.sv
// leg_queue_ram: 2^AW x WIDTH storage, synchronous write, asynchronous read, no reset.
module leg_queue_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/leg_queue.sv
// leg_queue: FIFO with stack-style PUSH/POP interface and switched OUTPUT for an OR-bus.
// Optional LEG_QUEUE_BYPASS_EN: push+pop on an empty queue forwards VALUE straight to OUTPUT.
module leg_queue
    import leg_queue_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic      clk,
    input  logic      rst,
    leg_queue_if.slave q
);
    localparam int AW = DEPTH_LOG2;
    localparam int CW = count_width(DEPTH_LOG2);
    localparam logic [CW-1:0] FULL_CNT = CW'(1) << DEPTH_LOG2;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             empty, full, bypass, pop_ok, push_ok;
    logic [WIDTH-1:0] rd_data;

`ifdef LEG_QUEUE_BYPASS_EN
    assign bypass = q.PUSH & q.POP & empty;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        empty    = count_q == '0;
        full     = count_q == FULL_CNT;
        pop_ok   = q.POP & ~empty;
        // A pop in the same cycle frees the slot, so a full queue still accepts the push.
        push_ok  = q.PUSH & (~full | pop_ok) & ~bypass;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        err_d    = err_q | (q.PUSH & full & ~pop_ok) | (q.POP & empty & ~bypass);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    leg_queue_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (push_ok & rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (q.VALUE),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign q.OUTPUT = pop_ok ? rd_data : bypass ? q.VALUE : '0;
    assign q.EMPTY  = empty;
    assign q.FULL   = full;
    assign q.COUNT  = count_q;
    assign q.ERR    = err_q;
endmodule

// File: tb/tb_leg_queue.sv
// tb_leg_queue: directed stimulus with a scoreboard of expected OUTPUT values on pop cycles.
module tb_leg_queue;
    import leg_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_q [$];

`ifdef LEG_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    leg_queue_if #(.WIDTH(8), .DEPTH_LOG2(8)) q ();
    leg_queue #(.WIDTH(8), .DEPTH_LOG2(8)) dut (.clk(clk), .rst(rst), .q(q));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with POP asserted presents an OUTPUT that the scoreboard predicts.
    always @(negedge clk) begin
        if (rst && q.POP) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("output", int'(q.OUTPUT), int'(exp_q.pop_front()));
        end
    end

    task automatic drive(input bit p, input bit o, input logic [7:0] v, input logic [7:0] e);
        q.PUSH  = p;
        q.POP   = o;
        q.VALUE = v;
        if (o) exp_q.push_back(e);
        @(posedge clk);
        #1;
        q.PUSH = 1'b0;
        q.POP  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, 8'(i), 8'h00);
    endtask

    initial begin
        q.PUSH  = 1'b0;
        q.POP   = 1'b0;
        q.VALUE = 8'h00;
        #12;
        chk("rst_empty", int'(q.EMPTY), 1);
        chk("rst_full", int'(q.FULL), 0);
        chk("rst_count", int'(q.COUNT), 0);
        chk("rst_err", int'(q.ERR), 0);
        chk("rst_output", int'(q.OUTPUT), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 8'h00, 8'h00);
        chk("underflow_err", int'(q.ERR), 1);
        chk("underflow_count", int'(q.COUNT), 0);

        do_reset();
        drive(1'b1, 1'b0, 8'h11, 8'h00);
        drive(1'b1, 1'b0, 8'h22, 8'h00);
        drive(1'b1, 1'b0, 8'h33, 8'h00);
        chk("three_count", int'(q.COUNT), 3);
        drive(1'b0, 1'b1, 8'h00, 8'h11);
        chk("pop1_count", int'(q.COUNT), 2);
        drive(1'b0, 1'b1, 8'h00, 8'h22);
        chk("pop2_count", int'(q.COUNT), 1);
        drive(1'b0, 1'b1, 8'h00, 8'h33);
        chk("pop3_count", int'(q.COUNT), 0);
        chk("pop3_empty", int'(q.EMPTY), 1);
        chk("pop3_err", int'(q.ERR), 0);

        do_reset();
        fill();
        chk("fill_full", int'(q.FULL), 1);
        chk("fill_count", int'(q.COUNT), 256);
        chk("fill_err", int'(q.ERR), 0);
        drive(1'b1, 1'b0, 8'hAA, 8'h00);
        chk("overflow_count", int'(q.COUNT), 256);
        chk("overflow_err", int'(q.ERR), 1);
        for (int i = 0; i < 256; i++) drive(1'b0, 1'b1, 8'h00, 8'(i));
        chk("drain_empty", int'(q.EMPTY), 1);

        do_reset();
        fill();
        drive(1'b1, 1'b1, 8'h5A, 8'h00);
        chk("fullpp_count", int'(q.COUNT), 256);
        chk("fullpp_err", int'(q.ERR), 0);
        for (int i = 1; i < 256; i++) drive(1'b0, 1'b1, 8'h00, 8'(i));
        drive(1'b0, 1'b1, 8'h00, 8'h5A);
        chk("wrap_empty", int'(q.EMPTY), 1);

        do_reset();
        drive(1'b1, 1'b1, 8'h77, BYP ? 8'h77 : 8'h00);
        chk("emptypp_count", int'(q.COUNT), BYP ? 0 : 1);
        chk("emptypp_err", int'(q.ERR), BYP ? 0 : 1);

        do_reset();
        drive(1'b0, 1'b1, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h01, 8'h00);
        drive(1'b1, 1'b0, 8'h02, 8'h00);
        drive(1'b1, 1'b0, 8'h03, 8'h00);
        chk("pre_async_count", int'(q.COUNT), 3);
        rst = 1'b0;
        #2;
        chk("async_count", int'(q.COUNT), 0);
        chk("async_empty", int'(q.EMPTY), 1);
        chk("async_err", int'(q.ERR), 0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 8'h44, 8'h00);
        drive(1'b0, 1'b1, 8'h00, 8'h44);
        chk("post_async_empty", int'(q.EMPTY), 1);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/leg_queue.md
Name: leg_queue

Overview:
- FIFO companion to the LEG stack: same PUSH/POP/VALUE/OUTPUT interface, but POP reads the oldest entry instead of the newest.
- Used as a CPU-side I/O buffer and as a program-visible queue device on the LEG data bus.
- Write pointer, read pointer and occupancy count are all registered.
- Storage is a dual-port RAM: synchronous write, asynchronous read.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH_LOG2, 8, log2 of the entry count (default depth 256). Pointers are DEPTH_LOG2 bits wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- PUSH  in  1  enqueue VALUE this cycle.
- POP  in  1  dequeue the head entry this cycle.
- VALUE  in  WIDTH  data to enqueue.
- OUTPUT  out  WIDTH  head data while popping, else 0.
- EMPTY  out  1  count == 0.
- FULL  out  1  count == 2^DEPTH_LOG2.
- COUNT  out  DEPTH_LOG2+1  current occupancy.
- ERR  out  1  sticky flag: overflow or underflow attempted.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, ERR=0. Consequently EMPTY=1, FULL=0, COUNT=0, OUTPUT=0. RAM contents are not cleared.
- OUTPUT is combinational: OUTPUT = mem[rd_ptr] when POP=1 and EMPTY=0, else 0. This matches the stack's switched output, so the block can share an OR-bus.
- Accepted push (PUSH=1, and either not FULL or POP also accepted):
  - mem[wr_ptr] <= VALUE at the edge.
  - wr_ptr increments mod 2^DEPTH_LOG2.
- Accepted pop (POP=1, not EMPTY): rd_ptr increments mod 2^DEPTH_LOG2. Data is visible on OUTPUT in the same cycle (zero latency).
- count update: count + accepted_push - accepted_pop.
- Pointer wrap: natural binary rollover. FULL/EMPTY are derived from count, never from pointer equality.
- Push and pop in the same cycle:
  - Not empty, not full: both happen; count unchanged.
  - FULL: both happen. OUTPUT shows the old head. The write lands in the slot being freed (wr_ptr == rd_ptr); the async read precedes the edge write. count stays full.
  - EMPTY: the push is accepted and the pop is rejected (OUTPUT=0, ERR set). Exception: see QUEUE_BYPASS_EN.
- Overflow (PUSH while FULL, no POP): write dropped, state unchanged, ERR <= 1.
- Underflow (POP while EMPTY): OUTPUT=0, pointers unchanged, ERR <= 1.
- ERR clears only on reset.
- Reset asserted mid-operation: immediate return to reset values. Any write in that cycle is lost.

Optional Feature:
- Macro: LEG_QUEUE_BYPASS_EN.
- Defined: PUSH=1 and POP=1 while EMPTY gives OUTPUT=VALUE combinationally. Nothing is stored, pointers and count are unchanged, and ERR is not set.
- Undefined: the rule above applies (push stored, pop rejected, ERR set).

Decomposition:
- Package leg_queue_pkg:
  - default WIDTH and DEPTH_LOG2 constants;
  - count type, as a parameterised width function;
  - localparam DEPTH = 1 << DEPTH_LOG2.
- Sub-module leg_queue_ram: 2^DEPTH_LOG2 x WIDTH storage, one synchronous write port and one asynchronous read port, no reset.
- Pointer, count and flag logic stay in leg_queue.

Test Plan:
- Reset then idle: EMPTY=1, COUNT=0, ERR=0. POP with no PUSH gives OUTPUT=0x00 and ERR=1 the following cycle.
- Push 0x11, 0x22, 0x33, then pop three times: OUTPUT reads 0x11, 0x22, 0x33 on the pop cycles. COUNT goes 3, 2, 1, 0; EMPTY=1 at the end.
- Fill with 256 pushes of values 0x00..0xFF: FULL=1, COUNT=256. A 257th push of 0xAA leaves COUNT=256 and sets ERR=1. Draining then returns 0x00..0xFF in order.
- While FULL (head=0x00), push 0x5A and pop together: OUTPUT=0x00, COUNT=256. After 255 further pops, the last pop returns 0x5A (pointer wrap verified).
- Push and pop together while EMPTY with VALUE=0x77:
  - Bypass undefined: OUTPUT=0, COUNT=1, ERR=1.
  - Bypass defined: OUTPUT=0x77, COUNT=0, ERR=0.
- Drop rst for half a cycle after three pushes: COUNT=0, EMPTY=1, ERR=0 asynchronously. The next push/pop of 0x44 returns 0x44.
